// File: rtl/mb_sp_ram_pkg.sv
// Shared helpers for the multi-port banked RAM: geometry derivation,
// parameter legality checks and the byte-lane type used by the banks.
package mb_sp_ram_pkg;

    typedef logic [7:0] byte_t;

    function automatic int bank_bits(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 0;
    endfunction

    // A bank always gets at least one row-address bit so its port is never zero-width.
    function automatic int row_bits(input int num_words, input int num_banks);
        return ((num_words / num_banks) > 1) ? $clog2(num_words / num_banks) : 1;
    endfunction

    function automatic bit lat_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 1) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/mb_sp_ram_if.sv
// Request/response bundle for all ports of mb_sp_ram; suffixes are from
// the RAM's point of view (slave modport).
interface mb_sp_ram_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_PORTS-1:0]                     req_i;
    logic [NUM_PORTS-1:0]                     gnt_o;
    logic [NUM_PORTS-1:0]                     we_i;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]     addr_i;
    logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]   be_i;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     wdata_i;
    logic [NUM_PORTS-1:0]                     rvalid_o;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     rdata_o;

    modport master (
        output req_i, we_i, addr_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, we_i, addr_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/mb_sp_ram_bank.sv
// One single-port byte-enable bank with registered read data.
// Contents are deliberately not reset.
module ram_bank
    import mb_sp_ram_pkg::*;
#(
    parameter int ROW_BITS   = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                    clk,
    input  logic                    en_i,
    input  logic                    we_i,
    input  logic [ROW_BITS-1:0]     row_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);
    byte_t [DATA_WIDTH/8-1:0] mem [DEPTH];
    logic  [DATA_WIDTH-1:0]   rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < DATA_WIDTH / 8; i++) begin
                    if (be_i[i]) mem[row_i][i] <= wdata_i[8*i +: 8];
                end
            end
            rdata_q <= mem[row_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/mb_sp_ram.sv
// Multi-port RAM over word-interleaved single-port banks, with per-bank
// round-robin arbitration and a fixed 1- or 2-cycle response pipeline.
module mb_sp_ram
    import mb_sp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_WORDS    = 1024,
    parameter int NUM_BANKS    = 4,
    parameter int NUM_PORTS    = 2,
    parameter int READ_LATENCY = 1
) (
    input logic        clk,
    input logic        rst_i,
    mb_sp_ram_if.slave bus
);
    localparam int BANK_BITS = bank_bits(NUM_BANKS);
    localparam int ROW_BITS  = row_bits(NUM_WORDS, NUM_BANKS);
    localparam int DEPTH     = NUM_WORDS / NUM_BANKS;
    localparam int PID_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int BE_W      = DATA_WIDTH / 8;

    if (NUM_WORDS % NUM_BANKS != 0) begin : g_err_words
        $error("mb_sp_ram: NUM_WORDS must be a multiple of NUM_BANKS");
    end
    if (!is_pow2(NUM_BANKS)) begin : g_err_banks
        $error("mb_sp_ram: NUM_BANKS must be a power of two");
    end
    if (!lat_ok(READ_LATENCY)) begin : g_err_lat
        $error("mb_sp_ram: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_err_width
        $error("mb_sp_ram: DATA_WIDTH must be a multiple of 8");
    end

    logic [ADDR_WIDTH-1:0]                bsel [NUM_PORTS];
    logic [NUM_PORTS-1:0]                 oor;
    logic [NUM_BANKS-1:0][NUM_PORTS-1:0]  win;
    logic [NUM_BANKS-1:0]                 any, b_en, b_we, b_oor;
    logic [PID_W-1:0]                     wid [NUM_BANKS];
    logic [PID_W-1:0]                     ptr_d [NUM_BANKS];
    logic [PID_W-1:0]                     ptr_q [NUM_BANKS];
    logic [ROW_BITS-1:0]                  b_row [NUM_BANKS];
    logic [BE_W-1:0]                      b_be [NUM_BANKS];
    logic [DATA_WIDTH-1:0]                b_wd [NUM_BANKS];
    logic [DATA_WIDTH-1:0]                bank_rd [NUM_BANKS];
    logic [NUM_PORTS-1:0]                 gnt;
    int                                   idx;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            bsel[p] = bus.addr_i[p] & ADDR_WIDTH'(NUM_BANKS - 1);
            oor[p]  = 32'(bus.addr_i[p]) >= 32'(NUM_WORDS);
        end
    end

    // Per bank: scan ports starting at the pointer; the first hit wins and also steers the bank inputs.
    always_comb begin
        any   = '0;
        win   = '0;
        b_en  = '0;
        b_we  = '0;
        b_oor = '0;
        idx   = 0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            wid[b]   = '0;
            ptr_d[b] = ptr_q[b];
            b_row[b] = '0;
            b_be[b]  = '0;
            b_wd[b]  = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                idx = int'(ptr_q[b]) + i;
                if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
                if (!any[b] && bus.req_i[idx] && !rst_i && bsel[idx] == ADDR_WIDTH'(b)) begin
                    any[b]      = 1'b1;
                    win[b][idx] = 1'b1;
                    wid[b]      = PID_W'(idx);
                    ptr_d[b]    = (idx == NUM_PORTS - 1) ? '0 : PID_W'(idx + 1);
                    b_en[b]     = !oor[idx];
                    b_we[b]     = bus.we_i[idx];
                    b_oor[b]    = oor[idx];
                    b_row[b]    = ROW_BITS'(bus.addr_i[idx] >> BANK_BITS);
                    b_be[b]     = bus.be_i[idx];
                    b_wd[b]     = bus.wdata_i[idx];
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int b = 0; b < NUM_BANKS; b++) gnt |= win[b];
    end
    assign bus.gnt_o = gnt;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        ram_bank #(.ROW_BITS(ROW_BITS), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_bank (
            .clk     (clk),
            .en_i    (b_en[b]),
            .we_i    (b_we[b]),
            .row_i   (b_row[b]),
            .be_i    (b_be[b]),
            .wdata_i (b_wd[b]),
            .rdata_o (bank_rd[b])
        );
    end

    logic [NUM_BANKS-1:0]  v1_q, rd1_q, oor1_q;
    logic [PID_W-1:0]      pid1_q [NUM_BANKS];
    logic [DATA_WIDTH-1:0] s1_d [NUM_BANKS];
    logic [NUM_BANKS-1:0]  rsp_v, rsp_rd;
    logic [PID_W-1:0]      rsp_pid [NUM_BANKS];
    logic [DATA_WIDTH-1:0] rsp_d [NUM_BANKS];

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            v1_q   <= '0;
            rd1_q  <= '0;
            oor1_q <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                pid1_q[b] <= '0;
                ptr_q[b]  <= '0;
            end
        end else begin
            v1_q   <= any;
            rd1_q  <= ~b_we;
            oor1_q <= b_oor;
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (any[b]) pid1_q[b] <= wid[b];
                ptr_q[b] <= ptr_d[b];
            end
        end
    end

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) s1_d[b] = oor1_q[b] ? '0 : bank_rd[b];
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [NUM_BANKS-1:0]  v2_q, rd2_q;
        logic [PID_W-1:0]      pid2_q [NUM_BANKS];
        logic [DATA_WIDTH-1:0] d2_q [NUM_BANKS];

        always_ff @(posedge clk or posedge rst_i) begin
            if (rst_i) begin
                v2_q  <= '0;
                rd2_q <= '0;
                for (int b = 0; b < NUM_BANKS; b++) begin
                    pid2_q[b] <= '0;
                    d2_q[b]   <= '0;
                end
            end else begin
                v2_q  <= v1_q;
                rd2_q <= rd1_q;
                for (int b = 0; b < NUM_BANKS; b++) begin
                    pid2_q[b] <= pid1_q[b];
                    d2_q[b]   <= s1_d[b];
                end
            end
        end

        always_comb begin
            rsp_v  = v2_q;
            rsp_rd = rd2_q;
            for (int b = 0; b < NUM_BANKS; b++) begin
                rsp_pid[b] = pid2_q[b];
                rsp_d[b]   = d2_q[b];
            end
        end
    end else begin : g_lat1
        always_comb begin
            rsp_v  = v1_q;
            rsp_rd = rd1_q;
            for (int b = 0; b < NUM_BANKS; b++) begin
                rsp_pid[b] = pid1_q[b];
                rsp_d[b]   = s1_d[b];
            end
        end
    end

    logic [NUM_PORTS-1:0]                 rvalid;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_d, rdata_q;

    // A port owns at most one bank per cycle, so at most one response targets it.
    always_comb begin
        rvalid  = '0;
        rdata_d = rdata_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (rsp_v[b] && rsp_pid[b] == PID_W'(p)) begin
                    rvalid[p] = 1'b1;
                    if (rsp_rd[b]) rdata_d[p] = rsp_d[b];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) rdata_q <= '0;
        else       rdata_q <= rdata_d;
    end

    assign bus.rvalid_o = rvalid;
    assign bus.rdata_o  = rdata_d;
endmodule

// File: tb/tb_mb_sp_ram.sv
// Drives identical traffic into a latency-1 and a latency-2 instance; a
// scoreboard keyed on grant cycle checks every response's timing and data.
module tb_mb_sp_ram;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int NW = 1024;
    localparam int NB = 4;
    localparam int NP = 2;

    typedef struct packed {
        int            due;
        logic          rd;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic [NP-1:0]          req = '0;
    logic [NP-1:0]          we = '0;
    logic [NP-1:0][AW-1:0]  addr = '0;
    logic [NP-1:0][3:0]     be = '0;
    logic [NP-1:0][DW-1:0]  wdata = '0;

    mb_sp_ram_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
    mb_sp_ram_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

    assign bus1.req_i = req;   assign bus2.req_i = req;
    assign bus1.we_i = we;     assign bus2.we_i = we;
    assign bus1.addr_i = addr; assign bus2.addr_i = addr;
    assign bus1.be_i = be;     assign bus2.be_i = be;
    assign bus1.wdata_i = wdata; assign bus2.wdata_i = wdata;

    mb_sp_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW), .NUM_BANKS(NB),
                .NUM_PORTS(NP), .READ_LATENCY(1)) u_lat1 (.clk(clk), .rst_i(rst), .bus(bus1));
    mb_sp_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW), .NUM_BANKS(NB),
                .NUM_PORTS(NP), .READ_LATENCY(2)) u_lat2 (.clk(clk), .rst_i(rst), .bus(bus2));

    logic [NP-1:0]         rvs [2];
    logic [NP-1:0][DW-1:0] rds [2];
    assign rvs[0] = bus1.rvalid_o;
    assign rvs[1] = bus2.rvalid_o;
    assign rds[0] = bus1.rdata_o;
    assign rds[1] = bus2.rdata_o;

    exp_t          q [2][NP][$];
    logic [DW-1:0] last_rd [2][NP];
    logic [DW-1:0] model [NW];

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < NP; p++) begin
                    if (rvs[d][p]) begin
                        n_vec++;
                        if (q[d][p].size() == 0) begin
                            n_err++;
                            $display("FAIL rsp_unexpected lat%0d port%0d cyc %0d: rvalid 1, want 0", d + 1, p, cyc);
                        end else begin
                            e = q[d][p].pop_front();
                            if (e.due != cyc) begin
                                n_err++;
                                $display("FAIL rsp_latency lat%0d port%0d: got cyc %0d want %0d", d + 1, p, cyc, e.due);
                            end
                            n_vec++;
                            if (e.rd) begin
                                if (rds[d][p] !== e.data) begin
                                    n_err++;
                                    $display("FAIL rsp_rdata lat%0d port%0d: got %h want %h", d + 1, p, rds[d][p], e.data);
                                end
                                last_rd[d][p] = e.data;
                            end else if (rds[d][p] !== last_rd[d][p]) begin
                                n_err++;
                                $display("FAIL rsp_hold lat%0d port%0d: got %h want %h", d + 1, p, rds[d][p], last_rd[d][p]);
                            end
                        end
                    end else if (q[d][p].size() != 0 && q[d][p][0].due <= cyc) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL rsp_missing lat%0d port%0d: no rvalid at cyc %0d", d + 1, p, q[d][p][0].due);
                        void'(q[d][p].pop_front());
                    end
                end
            end
        end
    end

    task automatic clear_expect();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < NP; p++) begin
                q[d][p].delete();
                last_rd[d][p] = '0;
            end
        end
    endtask

    task automatic set_port(input int p, input logic w, input logic [AW-1:0] a,
                            input logic [3:0] b, input logic [DW-1:0] dat);
        req[p] = 1'b1; we[p] = w; addr[p] = a; be[p] = b; wdata[p] = dat;
    endtask

    // One arbitration cycle: sample grants, book expected responses, update the model.
    task automatic step(output logic [NP-1:0] g);
        exp_t e;
        @(negedge clk);
        g = bus1.gnt_o;
        for (int p = 0; p < NP; p++) begin
            if (g[p]) begin
                e.rd   = !we[p];
                e.data = (!we[p] && addr[p] < NW) ? model[addr[p][9:0]] : '0;
                e.due  = cyc + 1;
                q[0][p].push_back(e);
                e.due  = cyc + 2;
                q[1][p].push_back(e);
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (g[p] && we[p] && addr[p] < NW) begin
                for (int b = 0; b < 4; b++)
                    if (be[p][b]) model[addr[p][9:0]][8*b +: 8] = wdata[p][8*b +: 8];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 2'b11; we = '0; addr[0] = 11'd0; addr[1] = 11'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (bus1.gnt_o !== 2'b00) begin n_err++; $display("FAIL reset_gnt lat1: got %b want 00", bus1.gnt_o); end
        n_vec++;
        if (bus2.gnt_o !== 2'b00) begin n_err++; $display("FAIL reset_gnt lat2: got %b want 00", bus2.gnt_o); end
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (rvs[d] !== 2'b00) begin n_err++; $display("FAIL reset_rvalid lat%0d: got %b want 00", d + 1, rvs[d]); end
            n_vec++;
            if (rds[d] !== '0) begin n_err++; $display("FAIL reset_rdata lat%0d: got %h want 0", d + 1, rds[d]); end
        end
        @(posedge clk);
        #1;
        req = '0;
        rst = 1'b0;
        clear_expect();
        idle(2);
    endtask

    task automatic test_write_read();
        logic [NP-1:0] g;
        set_port(0, 1'b1, 11'd5, 4'hF, 32'hDEADBEEF);
        step(g);
        n_vec++;
        if (g !== 2'b01) begin n_err++; $display("FAIL wr_gnt: got %b want 01", g); end
        set_port(0, 1'b0, 11'd5, 4'h0, 32'h0);
        step(g);
        n_vec++;
        if (g !== 2'b01) begin n_err++; $display("FAIL rd_gnt: got %b want 01", g); end
        idle(3);
    endtask

    task automatic test_byte_enable();
        logic [NP-1:0] g;
        logic [DW-1:0] dat [3];
        logic [3:0]    bes [3];
        logic          wes [3];
        dat = '{32'h11223344, 32'hAABBCCDD, 32'h0};
        bes = '{4'hF, 4'h5, 4'h0};
        wes = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            set_port(0, wes[i], 11'd8, bes[i], dat[i]);
            step(g);
            n_vec++;
            if (g !== 2'b01) begin n_err++; $display("FAIL be_gnt step%0d: got %b want 01", i, g); end
        end
        idle(3);
    endtask

    task automatic test_contention();
        logic [NP-1:0] g;
        logic [NP-1:0] want;
        set_port(0, 1'b1, 11'd1, 4'hF, 32'hA1A1A1A1);
        step(g);
        n_vec++;
        if (g !== 2'b01) begin n_err++; $display("FAIL cont_init0_gnt: got %b want 01", g); end
        req = '0;
        set_port(1, 1'b1, 11'd5, 4'hF, 32'hB5B5B5B5);
        step(g);
        n_vec++;
        if (g !== 2'b10) begin n_err++; $display("FAIL cont_init1_gnt: got %b want 10", g); end
        set_port(0, 1'b0, 11'd1, 4'h0, 32'h0);
        set_port(1, 1'b0, 11'd5, 4'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            step(g);
            n_vec++;
            if (g !== want) begin n_err++; $display("FAIL cont_gnt cycle%0d: got %b want %b", i, g, want); end
        end
        idle(3);
    endtask

    task automatic test_diff_banks();
        logic [NP-1:0] g;
        set_port(0, 1'b1, 11'd0, 4'hF, 32'h0A0B0C0D);
        set_port(1, 1'b1, 11'd1, 4'hF, 32'h01020304);
        step(g);
        n_vec++;
        if (g !== 2'b11) begin n_err++; $display("FAIL diff_wr_gnt: got %b want 11", g); end
        set_port(0, 1'b0, 11'd0, 4'h0, 32'h0);
        set_port(1, 1'b0, 11'd1, 4'h0, 32'h0);
        step(g);
        n_vec++;
        if (g !== 2'b11) begin n_err++; $display("FAIL diff_rd_gnt: got %b want 11", g); end
        idle(3);
    endtask

    task automatic test_out_of_range();
        logic [NP-1:0] g;
        logic [AW-1:0] adr [4];
        logic          wes [4];
        logic [DW-1:0] dat [4];
        adr = '{11'd0, 11'd1024, 11'd1024, 11'd0};
        wes = '{1'b1, 1'b1, 1'b0, 1'b0};
        dat = '{32'h12345678, 32'hFFFFFFFF, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            set_port(0, wes[i], adr[i], 4'hF, dat[i]);
            step(g);
            n_vec++;
            if (g !== 2'b01) begin n_err++; $display("FAIL oor_gnt step%0d: got %b want 01", i, g); end
        end
        idle(3);
    endtask

    task automatic test_back_to_back();
        logic [NP-1:0] g;
        for (int i = 0; i < 8; i++) begin
            set_port(1, (i < 4), AW'(16 + (i % 4)), 4'hF, $urandom);
            step(g);
            n_vec++;
            if (g !== 2'b10) begin n_err++; $display("FAIL b2b_gnt step%0d: got %b want 10", i, g); end
        end
        idle(4);
    endtask

    task automatic test_reset_midop();
        logic [NP-1:0] g;
        set_port(0, 1'b0, 11'd5, 4'h0, 32'h0);
        step(g);
        n_vec++;
        if (g !== 2'b01) begin n_err++; $display("FAIL midrst_gnt: got %b want 01", g); end
        rst = 1'b1;
        req = '0;
        clear_expect();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if (rvs[d] !== 2'b00) begin n_err++; $display("FAIL midrst_rvalid lat%0d: got %b want 00", d + 1, rvs[d]); end
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if (rvs[d] !== 2'b00) begin n_err++; $display("FAIL postrst_rvalid lat%0d: got %b want 00", d + 1, rvs[d]); end
            end
        end
        @(posedge clk);
        #1;
        set_port(0, 1'b0, 11'd5, 4'h0, 32'h0);
        set_port(1, 1'b0, 11'd1, 4'h0, 32'h0);
        step(g);
        n_vec++;
        if (g !== 2'b01) begin n_err++; $display("FAIL postrst_ptr_gnt0: got %b want 01", g); end
        step(g);
        n_vec++;
        if (g !== 2'b10) begin n_err++; $display("FAIL postrst_ptr_gnt1: got %b want 10", g); end
        idle(4);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_contention();
        test_diff_banks();
        test_out_of_range();
        test_back_to_back();
        test_reset_midop();
        idle(4);
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < NP; p++) begin
                n_vec++;
                if (q[d][p].size() != 0) begin
                    n_err++;
                    $display("FAIL drain lat%0d port%0d: %0d responses outstanding, want 0", d + 1, p, q[d][p].size());
                end
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mb_sp_ram.md
# mb_sp_ram

Multi-port, multi-bank on-chip RAM that generalises the single-port byte-enable RAM used behind the AXI memory slaves. NUM_PORTS independent request ports share NUM_BANKS word-interleaved single-port banks; each port has a req/gnt handshake, and each bank has round-robin arbitration. Read latency is fixed and configurable. Sits between the AXI-to-mem adapters (or core LSU ports) and the physical SRAM macros.

## Interface
- ADDR_WIDTH, 10, word-address width per port
- DATA_WIDTH, 32, data width in bits; multiple of 8
- NUM_WORDS, 1024, total words across all banks; multiple of NUM_BANKS
- NUM_BANKS, 4, power of two, ≥1
- NUM_PORTS, 2, request ports, ≥1
- READ_LATENCY, 1, 1 or 2 cycles grant-to-rvalid
- clk  in  1  clock; all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- req_i  in  [NUM_PORTS]  port request valid
- gnt_o  out  [NUM_PORTS]  grant; combinational from req_i/addr_i and arbiter state
- we_i  in  [NUM_PORTS]  1 = write, 0 = read
- addr_i  in  [NUM_PORTS][ADDR_WIDTH]  word address
- be_i  in  [NUM_PORTS][DATA_WIDTH/8]  byte enables (writes only)
- wdata_i  in  [NUM_PORTS][DATA_WIDTH]  write data
- rvalid_o  out  [NUM_PORTS]  response pulse for every granted request (read or write)
- rdata_o  out  [NUM_PORTS][DATA_WIDTH]  read data, valid when rvalid_o and request was a read

## Operation
- Bank select = addr_i[log2(NUM_BANKS)-1:0]; row = addr_i >> log2(NUM_BANKS). NUM_BANKS=1 → bank 0, row = addr_i.
- Per bank, per cycle, at most one requesting port granted. Single requester → granted same cycle. Multiple → round-robin: priority pointer per bank; search starts at pointer; after a grant pointer = granted port + 1 (mod NUM_PORTS). Pointer does not move in a cycle with no grant on that bank. Reset pointer = 0.
- Ports on different banks are all granted in the same cycle.
- Ungranted port must hold req_i, we_i, addr_i, be_i, wdata_i stable until granted; gnt_o only asserts when req_i is high.
- Write: bytes with be_i[b]=1 updated at the grant edge; others unchanged. be_i=0 → no change, still responds.
- Read: returns bank contents before any write in the same cycle (only one access per bank per cycle, so no intra-bank collision).
- Out-of-range (addr_i ≥ NUM_WORDS): granted normally; write discarded; read returns all-zero.
- rdata_o holds its previous value when no read response; only read responses update it.
- Memory array is not reset; contents undefined after power-up, retained across rst_i.

## Timing
- Grant at cycle T → rvalid_o pulse at T+READ_LATENCY, exactly one cycle wide; responses in grant order per port.
- READ_LATENCY=1: bank output drives response path directly. READ_LATENCY=2: extra output register stage (valid + data) after bank.
- Back-to-back grants to one port every cycle sustain one response per cycle.
- Reset values: rvalid_o=0, rdata_o=0, all arbiter pointers=0, pipeline valid bits=0. gnt_o=0 while rst_i is high.
- Reset asserted mid-operation: in-flight responses dropped (no rvalid_o after rst_i deasserts for pre-reset grants); a write granted on the same edge reset asserts is not guaranteed.

## Structure
- Package mb_sp_ram_pkg: BANK_BITS/ROW_BITS derivation functions, READ_LATENCY legal-value check, byte-lane typedef logic [7:0].
- Sub-module ram_bank: one single-port byte-enable bank (en, we, row addr, be, wdata, registered rdata), instantiated NUM_BANKS times; arbiter and response routing (per-bank granted-port-id pipeline matching READ_LATENCY) in the top.
- Elaboration-time assertions: NUM_WORDS % NUM_BANKS == 0, NUM_BANKS power of two, READ_LATENCY ∈ {1,2}, DATA_WIDTH % 8 == 0.

## Test plan
- Port 0 writes 0xDEADBEEF to addr 5 (be=0xF), then reads addr 5 → rvalid one cycle after read grant (LAT=1), rdata 0xDEADBEEF; repeat with LAT=2 → response two cycles after grant.
- Write 0x11223344 to addr 8, then write 0xAABBCCDD with be=0x5 → read returns 0x11BB33DD.
- Ports 0 and 1 both request bank 1 (addr 1, addr 5) continuously for 4 cycles → grants alternate 0,1,0,1; each port sees two rvalid pulses, data correct.
- Ports 0 and 1 request addr 0 and addr 1 (different banks) same cycle → both granted, both rvalid next cycle (LAT=1).
- Read addr NUM_WORDS (1024) → granted, rdata 0x00000000; write to 1024 does not alias addr 0.
- Grant read at T, assert rst_i at T+1 (LAT=2) → rvalid_o stays 0 through and after reset; pointers back to 0 (first contention after reset grants port 0).
